// File: rtl/ads868x_pkg.sv
// Shared types and constants for the ADS868x scan controller.
package ads868x_pkg;

   localparam int unsigned SAMPLE_W = 16;

   // Command word that leaves the ADC configuration untouched.
   localparam logic [31:0] ADS868X_CMD_NOP = 32'h0000_0000;

   typedef enum logic [2:0] {
      StIdle,
      StMux,
      StSettle,
      StConv,
      StShift,
      StPush
   } scan_state_e;

endpackage

// File: rtl/ads868x_scan_ctrl_if.sv
// Sample stream carrying {channel, sample} beats plus a per-scan timestamp.
interface ads868x_scan_ctrl_if
   import ads868x_pkg::*;
#(
   parameter int unsigned CH_W = 3
);
   logic [SAMPLE_W+CH_W-1:0] m_tdata;
   logic [31:0]              m_tuser;
   logic                     m_tlast;
   logic                     m_tvalid;
   logic                     m_tready;

   modport master (output m_tdata, output m_tuser, output m_tlast, output m_tvalid,
                   input m_tready);
   modport slave  (input m_tdata, input m_tuser, input m_tlast, input m_tvalid,
                   output m_tready);
endinterface

// File: rtl/ads868x_spi_frame.sv
// One SPI mode-0 frame: cs_n low, FRAME_W SCLK pulses, cs_n high one half-period after
// the last falling edge. MISO sampled on rise, MOSI advanced on fall.
module ads868x_spi_frame
   import ads868x_pkg::*;
#(
   parameter int unsigned FRAME_W  = 32,
   parameter int unsigned SCLK_DIV = 4
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                start,
   input  logic [FRAME_W-1:0]  cmd,
   input  logic                miso,
   output logic                done,
   output logic [SAMPLE_W-1:0] sample,
   output logic                cs_n,
   output logic                sclk,
   output logic                mosi
);
   localparam int unsigned DIV_W  = $clog2(SCLK_DIV);
   localparam int unsigned EDGE_W = $clog2(2 * FRAME_W + 1);

   logic               active_q;
   logic [DIV_W-1:0]   div_q;
   logic [EDGE_W-1:0]  edge_q;
   logic               sclk_q, cs_n_q, mosi_q, done_q;
   logic [FRAME_W-1:0] tx_q, rx_q;

   // Half-period divider; edge_q counts half-periods, the last one is the cs_n tail.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         active_q <= 1'b0;
         div_q    <= '0;
         edge_q   <= '0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         mosi_q   <= 1'b0;
         done_q   <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (start && !active_q) begin
            active_q <= 1'b1;
            cs_n_q   <= 1'b0;
            mosi_q   <= cmd[FRAME_W-1];
            tx_q     <= cmd;
            div_q    <= '0;
            edge_q   <= '0;
         end else if (active_q) begin
            if (div_q == DIV_W'(SCLK_DIV - 1)) begin
               div_q  <= '0;
               edge_q <= edge_q + EDGE_W'(1);
               if (edge_q == EDGE_W'(2 * FRAME_W)) begin
                  active_q <= 1'b0;
                  cs_n_q   <= 1'b1;
                  done_q   <= 1'b1;
               end else if (!sclk_q) begin
                  sclk_q <= 1'b1;
                  rx_q   <= {rx_q[FRAME_W-2:0], miso};
               end else begin
                  sclk_q <= 1'b0;
                  tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
                  mosi_q <= tx_q[FRAME_W-2];
               end
            end else begin
               div_q <= div_q + DIV_W'(1);
            end
         end
      end
   end

   assign done   = done_q;
   assign sample = rx_q[FRAME_W-1 -: SAMPLE_W];
   assign cs_n   = cs_n_q;
   assign sclk   = sclk_q;
   assign mosi   = mosi_q;
endmodule

// File: rtl/ads868x_scan_ctrl.sv
// Multi-channel scan sequencer for an ADS868x behind an analog mux.
// Optional feature macro: ADS868X_SCAN_TIMESTAMP_EN (per-scan 32-bit cycle stamp on m_tuser).
module ads868x_scan_ctrl
   import ads868x_pkg::*;
#(
   parameter int unsigned  NUM_CH     = 8,
   parameter int unsigned  FRAME_W    = 32,
   parameter int unsigned  SCLK_DIV   = 4,
   parameter int unsigned  SETTLE_CYC = 200,
   parameter int unsigned  CONV_CYC   = 120,
   localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                cfg_en,
   input  logic                cfg_cont,
   input  logic [NUM_CH-1:0]   cfg_mask,
   input  logic [FRAME_W-1:0]  cfg_cmd,
   input  logic                sw_start,
   input  logic                ptp_trg,
   input  logic                sts_clr,
   output logic                busy,
   output logic                sts_ovf,
   output logic                sts_trg_miss,
   output logic [CH_W-1:0]     ch_sel,
   output logic                adc_rst_n,
   output logic                spi_cs_n,
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   ads868x_scan_ctrl_if.master m_axis
);
   localparam int unsigned CNT_MAX = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   scan_state_e          state_q, state_d;
   logic [CH_W-1:0]      ch_q, ch_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_CH-1:0]    mask_q;
   logic [FRAME_W-1:0]   cmd_q;
   logic                 ptp_meta_q, ptp_sync_q, ptp_prev_q, ptp_rise, start_req;
   logic                 scan_start, frame_start, frame_done, push_evt, ovf_evt, miss_evt;
   logic [SAMPLE_W-1:0]  frame_sample;
   logic                 first_vld, next_vld;
   logic [CH_W-1:0]      first_ch, next_ch;
   logic                 ovf_q, miss_q, adc_rst_n_q;
   logic                 tvalid_q, tlast_q;
   logic [SAMPLE_W+CH_W-1:0] tdata_q;
   logic [31:0]          tuser_q, ts_scan;

   // Lowest enabled channel of the live mask, and next enabled channel of the latched mask.
   always_comb begin
      first_vld = 1'b0;
      first_ch  = '0;
      next_vld  = 1'b0;
      next_ch   = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (cfg_mask[i]) begin
            first_vld = 1'b1;
            first_ch  = CH_W'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_vld = 1'b1;
            next_ch  = CH_W'(i);
         end
      end
   end

   assign ptp_rise  = ptp_sync_q & ~ptp_prev_q;
   assign start_req = sw_start | ptp_rise;

   // Scan FSM next-state: mux, settle, convert, shift, push, then next channel or restart.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      cnt_d       = cnt_q;
      scan_start  = 1'b0;
      frame_start = 1'b0;
      push_evt    = 1'b0;
      miss_evt    = (state_q != StIdle) && start_req;
      case (state_q)
         StIdle: begin
            if (start_req && cfg_en && first_vld) begin
               scan_start = 1'b1;
               ch_d       = first_ch;
               state_d    = StMux;
            end
         end
         StMux: begin
            cnt_d   = '0;
            state_d = StSettle;
         end
         StSettle: begin
            if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = StConv;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StConv: begin
            if (cnt_q == CNT_W'(CONV_CYC - 1)) begin
               frame_start = 1'b1;
               state_d     = StShift;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StShift: begin
            if (frame_done) state_d = StPush;
         end
         StPush: begin
            push_evt = 1'b1;
            if (next_vld) begin
               ch_d    = next_ch;
               state_d = StMux;
            end else if (cfg_cont && cfg_en && first_vld) begin
               // Continuous restart is a fresh scan: relatch mask, command and timestamp.
               scan_start = 1'b1;
               ch_d       = first_ch;
               state_d    = StMux;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state, current channel and settle/convert counter.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= StIdle;
         ch_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
      end
   end

   // Scan configuration snapshot, trigger synchroniser, stickies and ADC reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         mask_q      <= '0;
         cmd_q       <= FRAME_W'(ADS868X_CMD_NOP);
         ptp_meta_q  <= 1'b0;
         ptp_sync_q  <= 1'b0;
         ptp_prev_q  <= 1'b0;
         ovf_q       <= 1'b0;
         miss_q      <= 1'b0;
         adc_rst_n_q <= 1'b0;
      end else begin
         if (scan_start) begin
            mask_q <= cfg_mask;
            cmd_q  <= cfg_cmd;
         end
         ptp_meta_q  <= ptp_trg;
         ptp_sync_q  <= ptp_meta_q;
         ptp_prev_q  <= ptp_sync_q;
         ovf_q       <= ovf_evt | (ovf_q & ~sts_clr);
         miss_q      <= miss_evt | (miss_q & ~sts_clr);
         adc_rst_n_q <= 1'b1;
      end
   end

`ifdef ADS868X_SCAN_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_scan_q;

   // Free-running cycle counter, captured at every scan start.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         ts_cnt_q  <= '0;
         ts_scan_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (scan_start) ts_scan_q <= ts_cnt_q;
      end
   end
   assign ts_scan = ts_scan_q;
`else
   assign ts_scan = '0;
`endif

   // A still-pending beat wins; the new sample is dropped so SPI timing never stalls.
   assign ovf_evt = push_evt & tvalid_q & ~m_axis.m_tready;

   // Single-entry output register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tuser_q  <= '0;
      end else if (push_evt && !ovf_evt) begin
         tvalid_q <= 1'b1;
         tdata_q  <= {ch_q, frame_sample};
         tlast_q  <= ~next_vld;
         tuser_q  <= ts_scan;
      end else if (m_axis.m_tready) begin
         tvalid_q <= 1'b0;
      end
   end

   ads868x_spi_frame #(
      .FRAME_W  (FRAME_W),
      .SCLK_DIV (SCLK_DIV)
   ) u_spi_frame (
      .aclk    (aclk),
      .aresetn (aresetn),
      .start   (frame_start),
      .cmd     (cmd_q),
      .miso    (spi_miso),
      .done    (frame_done),
      .sample  (frame_sample),
      .cs_n    (spi_cs_n),
      .sclk    (spi_sclk),
      .mosi    (spi_mosi)
   );

   assign busy            = (state_q != StIdle);
   assign sts_ovf         = ovf_q;
   assign sts_trg_miss    = miss_q;
   assign ch_sel          = ch_q;
   assign adc_rst_n       = adc_rst_n_q;
   assign m_axis.m_tvalid = tvalid_q;
   assign m_axis.m_tdata  = tdata_q;
   assign m_axis.m_tlast  = tlast_q;
   assign m_axis.m_tuser  = tuser_q;
endmodule
